// File: rtl/writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : writeback_arbiter                                            |
// | Description : Round-robin ALU/load write arbiter with FIFO drain onto the  |
// |               register file write port, plus RAW pending-status queries.   |
// |               Optional macro WB_FORWARD_EN adds youngest-write forwarding. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [31:0]     alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [31:0]     mem_data,
  input  logic            wr_stall,
  output logic            RegWrite,
  output logic [4:0]      WriteRegister,
  output logic [31:0]     WriteData,
  input  logic [4:0]      query_rs,
  input  logic [4:0]      query_rt,
  output logic            pending_rs,
  output logic            pending_rt,
  output logic [CNTW-1:0] level
`ifdef WB_FORWARD_EN
  ,
  output logic            fwd_rs_valid,
  output logic [31:0]     fwd_rs_data,
  output logic            fwd_rt_valid,
  output logic [31:0]     fwd_rt_data
`endif
);

  localparam int       c_AW  = $clog2(DEPTH);
  localparam logic [0:0] c_ALU = 1'b0;
  localparam logic [0:0] c_MEM = 1'b1;

  logic [4:0]      r_rdMem   [DEPTH];
  logic [31:0]     r_dataMem [DEPTH];
  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [CNTW-1:0] r_level;
  logic [0:0]      r_ptr;
  logic            r_regWrite;
  logic [4:0]      r_writeReg;
  logic [31:0]     r_writeData;

  logic            w_full;
  logic            w_aluAcc;
  logic            w_memAcc;
  logic [4:0]      w_accRd;
  logic [31:0]     w_accData;
  logic            w_push;
  logic            w_pop;
  logic [DEPTH-1:0] w_hitRs;
  logic [DEPTH-1:0] w_hitRt;

  assign w_full    = (r_level == CNTW'(DEPTH));
  assign mem_ready = !w_full && (!alu_valid || r_ptr == c_MEM);
  assign alu_ready = !w_full && (!mem_valid || r_ptr == c_ALU);
  assign w_aluAcc  = alu_valid && alu_ready;
  assign w_memAcc  = mem_valid && mem_ready;
  assign w_accRd   = w_memAcc ? mem_rd : alu_rd;
  assign w_accData = w_memAcc ? mem_data : alu_data;
  // rd==0 writes complete the handshake but never occupy the FIFO
  assign w_push    = (w_aluAcc || w_memAcc) && (w_accRd != 5'd0);
  assign w_pop     = (r_level != '0) && !wr_stall;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rdMem[r_tail]   <= w_accRd;
      r_dataMem[r_tail] <= w_accData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_level     <= '0;
      r_ptr       <= c_MEM;
      r_regWrite  <= 1'b0;
      r_writeReg  <= 5'd0;
      r_writeData <= 32'd0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head      <= r_head + 1'b1;
        r_regWrite  <= 1'b1;
        r_writeReg  <= r_rdMem[r_head];
        r_writeData <= r_dataMem[r_head];
      end else begin
        r_regWrite  <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_aluAcc) begin
        r_ptr <= c_MEM;
      end else if (w_memAcc) begin
        r_ptr <= c_ALU;
      end
    end
  end

  // An entry is live when its distance from the head is below the occupancy
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [c_AW-1:0] w_age;
      logic            w_live;
      assign w_age      = c_AW'(i) - r_head;
      assign w_live     = (CNTW'(w_age) < r_level);
      assign w_hitRs[i] = w_live && (r_rdMem[i] == query_rs);
      assign w_hitRt[i] = w_live && (r_rdMem[i] == query_rt);
    end
  endgenerate

  assign pending_rs = (query_rs != 5'd0) &&
                      ((|w_hitRs) || (r_regWrite && r_writeReg == query_rs));
  assign pending_rt = (query_rt != 5'd0) &&
                      ((|w_hitRt) || (r_regWrite && r_writeReg == query_rt));

  assign RegWrite      = r_regWrite;
  assign WriteRegister = r_writeReg;
  assign WriteData     = r_writeData;
  assign level         = r_level;

`ifdef WB_FORWARD_EN
  logic [c_AW-1:0] w_ordIdx [DEPTH];

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_ord
      assign w_ordIdx[k] = r_head + c_AW'(k);
    end
  endgenerate

  // Walk oldest to youngest so the youngest matching entry wins
  always_comb begin
    fwd_rs_data = r_writeData;
    fwd_rt_data = r_writeData;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_hitRs[w_ordIdx[k]]) begin
        fwd_rs_data = r_dataMem[w_ordIdx[k]];
      end
      if (w_hitRt[w_ordIdx[k]]) begin
        fwd_rt_data = r_dataMem[w_ordIdx[k]];
      end
    end
  end

  assign fwd_rs_valid = pending_rs;
  assign fwd_rt_valid = pending_rt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_writeback_arbiter                                         |
// | Description : Directed and random checks of writeback_arbiter against a    |
// |               queue-based reference model (honours WB_FORWARD_EN).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid, wr_stall;
  logic            alu_ready, mem_ready;
  logic [4:0]      alu_rd, mem_rd, query_rs, query_rt;
  logic [31:0]     alu_data, mem_data;
  logic            RegWrite;
  logic [4:0]      WriteRegister;
  logic [31:0]     WriteData;
  logic            pending_rs, pending_rt;
  logic [CNTW-1:0] level;
`ifdef WB_FORWARD_EN
  logic            fwd_rs_valid, fwd_rt_valid;
  logic [31:0]     fwd_rs_data, fwd_rt_data;
`endif

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wr_stall(wr_stall),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .query_rs(query_rs), .query_rt(query_rt),
    .pending_rs(pending_rs), .pending_rt(pending_rt), .level(level)
`ifdef WB_FORWARD_EN
    , .fwd_rs_valid(fwd_rs_valid), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_valid(fwd_rt_valid), .fwd_rt_data(fwd_rt_data)
`endif
  );

  int          nAssert = 0;
  int          nFail   = 0;
  logic [36:0] q[$];           // {rd, data}, front = oldest
  logic        turnMem;        // whose turn when both request
  logic        mRegWrite;
  logic [4:0]  mWReg;
  logic [31:0] mWData;
  logic        lastAluAcc, lastMemAcc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelPending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i][36:32] == r) return 1'b1;
    return mRegWrite && (mWReg == r);
  endfunction

  function automatic logic [31:0] modelFwd(input logic [4:0] r);
    logic [31:0] d;
    d = mWData;
    foreach (q[i]) if (q[i][36:32] == r) d = q[i][31:0];
    return d;
  endfunction

  task automatic modelReset();
    q.delete();
    turnMem   = 1'b1;
    mRegWrite = 1'b0;
    mWReg     = 5'd0;
    mWData    = 32'd0;
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge
  task automatic cycle();
    logic        full, expAluRdy, expMemRdy, aluAcc, memAcc;
    logic [36:0] e;
    @(negedge clk);
    full      = (q.size() == DEPTH);
    expAluRdy = !full && (mem_valid ? !turnMem : 1'b1);
    expMemRdy = !full && (alu_valid ?  turnMem : 1'b1);
    chk("alu_ready", 32'(alu_ready), 32'(expAluRdy));
    chk("mem_ready", 32'(mem_ready), 32'(expMemRdy));
    chk("level", 32'(level), 32'(q.size()));
    chk("RegWrite", 32'(RegWrite), 32'(mRegWrite));
    chk("WriteRegister", 32'(WriteRegister), 32'(mWReg));
    chk("WriteData", WriteData, mWData);
    chk("pending_rs", 32'(pending_rs), 32'(modelPending(query_rs)));
    chk("pending_rt", 32'(pending_rt), 32'(modelPending(query_rt)));
`ifdef WB_FORWARD_EN
    chk("fwd_rs_valid", 32'(fwd_rs_valid), 32'(modelPending(query_rs)));
    chk("fwd_rt_valid", 32'(fwd_rt_valid), 32'(modelPending(query_rt)));
    if (modelPending(query_rs)) chk("fwd_rs_data", fwd_rs_data, modelFwd(query_rs));
    if (modelPending(query_rt)) chk("fwd_rt_data", fwd_rt_data, modelFwd(query_rt));
`endif
    aluAcc = alu_valid && expAluRdy;
    memAcc = mem_valid && expMemRdy;
    @(posedge clk);
    if (rst) begin
      modelReset();
      aluAcc = 1'b0;
      memAcc = 1'b0;
    end else begin
      if (q.size() > 0 && !wr_stall) begin
        e         = q.pop_front();
        mRegWrite = 1'b1;
        mWReg     = e[36:32];
        mWData    = e[31:0];
      end else begin
        mRegWrite = 1'b0;
      end
      if (aluAcc && alu_rd != 5'd0) q.push_back({alu_rd, alu_data});
      if (memAcc && mem_rd != 5'd0) q.push_back({mem_rd, mem_data});
      if (aluAcc || memAcc) turnMem = aluAcc;
    end
    lastAluAcc = aluAcc;
    lastMemAcc = memAcc;
    #1;
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int ai, mi, nAcc;
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; wr_stall = 1'b0;
    alu_rd = 5'd0; alu_data = 32'd0; mem_rd = 5'd0; mem_data = 32'd0;
    query_rs = 5'd0; query_rt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rst = 1'b0;
    idle(1);

    // Single ALU write, tracked by the hazard query
    query_rs = 5'd5; query_rt = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    idle(4);

    // Both sources competing: grants must alternate starting with MEM
    ai = 1; mi = 9;
    query_rs = 5'd2; query_rt = 5'd10;
    for (int c = 0; c < 24 && (ai <= 4 || mi <= 12); c++) begin
      alu_valid = (ai <= 4); alu_rd = 5'(ai); alu_data = 32'hA000_0000 + 32'(ai);
      mem_valid = (mi <= 12); mem_rd = 5'(mi); mem_data = 32'hB000_0000 + 32'(mi);
      cycle();
      if (lastAluAcc) ai++;
      if (lastMemAcc) mi++;
    end
    chk("alu_all_granted", 32'(ai), 32'd5);
    chk("mem_all_granted", 32'(mi), 32'd13);
    idle(6);

    // Stall fills the FIFO; fifth request must be refused
    wr_stall = 1'b1;
    ai = 1;
    query_rs = 5'd1; query_rt = 5'd4;
    for (int c = 0; c < 12 && ai <= 5; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(ai); alu_data = 32'hC000_0000 + 32'(ai);
      cycle();
      if (lastAluAcc) ai++;
    end
    chk("stall_fill_accepts", 32'(ai), 32'd5);
    alu_valid = 1'b0;
    wr_stall  = 1'b0;
    idle(6);

    // rd==0 request: handshake only
    query_rs = 5'd0; query_rt = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    cycle();
    chk("rd0_accepted", 32'(lastAluAcc), 32'd1);
    idle(3);

    // Sustained push/pop across pointer wrap
    nAcc = 0;
    for (int c = 0; c < 20 && nAcc < 10; c++) begin
      mem_valid = 1'b1; mem_rd = 5'(nAcc + 16); mem_data = 32'hD000_0000 + 32'(nAcc);
      query_rs = 5'(nAcc + 16); query_rt = 5'(nAcc + 15);
      cycle();
      if (lastMemAcc) nAcc++;
    end
    chk("stream_accepts", 32'(nAcc), 32'd10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    mem_valid = 1'b0;
    idle(2);

`ifdef WB_FORWARD_EN
    // Youngest of two pending writes to the same register is forwarded
    wr_stall = 1'b1; query_rs = 5'd7; query_rt = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
    cycle();
    alu_data = 32'hB;
    cycle();
    alu_valid = 1'b0;
    cycle();
    chk("fwd_youngest", fwd_rs_data, 32'hB);
    wr_stall = 1'b0;
    idle(4);
`endif

    // Random traffic with a reset dropped in mid-stream
    for (int c = 0; c < 400; c++) begin
      rst       = (c == 200);
      alu_valid = ($urandom_range(0, 99) < 60);
      mem_valid = ($urandom_range(0, 99) < 60);
      alu_rd    = 5'($urandom_range(0, 15));
      mem_rd    = 5'($urandom_range(0, 15));
      alu_data  = $urandom;
      mem_data  = $urandom;
      wr_stall  = ($urandom_range(0, 99) < 25);
      query_rs  = 5'($urandom_range(0, 15));
      query_rt  = 5'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b0;
    wr_stall = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side initiator for the 32x32 register file.
- Accepts register-write requests from the ALU and load/memory result paths over valid/ready handshakes and arbitrates between them.
- Buffers accepted writes in a small FIFO and drains them one per cycle onto the register file's single write port (RegWrite/WriteRegister/WriteData).
- Reports per-register pending status so issue logic can detect read-after-write hazards.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNTW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU write request valid
alu_ready  output  1  ALU request accepted this cycle when high with alu_valid
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
mem_valid  input  1  load write request valid
mem_ready  output  1  load request accepted this cycle when high with mem_valid
mem_rd  input  5  load destination register
mem_data  input  32  load data
wr_stall  input  1  hold drain; no pop while high
RegWrite  output  1  register file write enable
WriteRegister  output  5  register file write address
WriteData  output  32  register file write data
query_rs  input  5  hazard query address 1
query_rt  input  5  hazard query address 2
pending_rs  output  1  uncommitted write to query_rs exists
pending_rt  output  1  uncommitted write to query_rt exists
level  output  CNTW  FIFO occupancy

Behaviour:
- Reset (synchronous, rst high at rising edge) applies regardless of other inputs:
  - FIFO empty, level=0.
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - Round-robin pointer = MEM.
  - In-flight entries are discarded; no partial write is emitted.
- Arbitration: at most one request accepted per cycle.
  - full = (level==DEPTH).
  - mem_ready = !full && (!alu_valid || ptr==MEM).
  - alu_ready = !full && (!mem_valid || ptr==ALU).
  - Ready signals are combinational from full, the other source's valid and ptr; no same-cycle push/pop pass-through, so ready=0 whenever full.
  - After any accepted transfer, ptr points to the other source.
  - Single requester is granted whenever !full.
- rd==0 requests: handshake completes normally (ready rules and ptr update apply) but the entry is not enqueued; level unchanged.
- Enqueue: an accepted non-zero request is written at the tail on the accepting edge; FIFO order = acceptance order.
- Drain, at each rising edge:
  - If level>0 and !wr_stall: pop head into output registers; RegWrite=1, WriteRegister=head.rd, WriteData=head.data for the following cycle.
  - Otherwise RegWrite=0; WriteRegister/WriteData hold their last values.
- Latency: request accepted at edge E0, earliest regfile write at edge E2 (RegWrite high between E1 and E2).
- Simultaneous push and pop: level unchanged; both take effect; pointers wrap modulo DEPTH.
- wr_stall: holds the FIFO contents and forces RegWrite=0 on the next cycle; requests are still accepted while not full.
- Pending flags (combinational):
  - pending_x = (query_x != 0) && (any valid FIFO entry has rd==query_x, or (RegWrite && WriteRegister==query_x)).
  - A register is pending until the cycle after its regfile write edge.
- level reports the FIFO entry count only, excluding the output stage.

Optional Feature:
WB_FORWARD_EN
- Defined: adds outputs fwd_rs_valid, fwd_rs_data[31:0], fwd_rt_valid, fwd_rt_data[31:0].
  - fwd_x_valid = pending_x.
  - fwd_x_data = data of the youngest matching write. Search order: FIFO tail toward head, then the output stage.
  - Fully combinational.
- Not defined: these ports are absent and no forwarding comparators or muxes are generated; all other behaviour is identical.

Test Plan:
1. Reset then alu_valid=1, rd=5, data=0xDEADBEEF, single cycle, wr_stall=0 -> alu_ready=1; RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF exactly one cycle later; level returns 0; pending_rs (query_rs=5) high from accept edge until the cycle after the write edge.
2. Both valid continuously (alu rd=1..4, mem rd=9..12), wr_stall=0 -> grants alternate MEM, ALU, MEM, ALU starting with MEM after reset; RegWrite sequence rd=9,1,10,2,...
3. wr_stall=1, push 4 ALU writes (rd=1..4) -> level=4, alu_ready=0 on the 5th request, RegWrite stays 0; release stall -> writes rd=1,2,3,4 on four consecutive cycles.
4. Write request with rd=0, data=0x1234 -> handshake completes, level stays 0, RegWrite never asserts, pending for query 0 stays 0.
5. DEPTH=4, sustained push and pop for 10 writes across pointer wrap -> output order matches acceptance order, level constant at steady state; assert rst mid-stream -> next cycle level=0, RegWrite=0, pending flags 0.
6. With WB_FORWARD_EN, enqueue rd=7 data=0xA then rd=7 data=0xB under stall, query_rs=7 -> fwd_rs_valid=1, fwd_rs_data=0xB.
